// File: rtl/onehot_decoder_fifo_pkg.sv
// Shared constants and sizing helpers for the one-hot decoder FIFO block.
package onehot_dec_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // An index bus is never narrower than one bit, even for a single lane.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int N_OUT_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int IDX_W     = idx_width(N_OUT_DEF);
  localparam int PTR_W     = clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/onehot_decoder_fifo_if.sv
// Index-in / one-hot-out handshake bundle for onehot_decoder_fifo.
interface onehot_decoder_fifo_if
  import onehot_dec_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int IDX_W = idx_width(N_OUT),
  parameter int DEPTH = DEPTH_DEF
) ();
  localparam int CW = clog2(DEPTH) + 1;

  logic [IDX_W-1:0] idx_i;
  logic             idx_valid_i;
  logic             idx_ready_o;
  logic [N_OUT-1:0] onehot_o;
  logic             onehot_valid_o;
  logic             onehot_ready_i;
  logic [CW-1:0]    count_o;
  logic             err_o;

  modport master (
    output idx_i, idx_valid_i, onehot_ready_i,
    input  idx_ready_o, onehot_o, onehot_valid_o, count_o, err_o
  );

  modport slave (
    input  idx_i, idx_valid_i, onehot_ready_i,
    output idx_ready_o, onehot_o, onehot_valid_o, count_o, err_o
  );
endinterface

// File: rtl/onehot_decoder_fifo_sync_fifo_ptr.sv
// WIDTH x DEPTH synchronous FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module sync_fifo_ptr
  import onehot_dec_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;

  // DEPTH is a power of 2, so a plain increment wraps the address and
  // toggles the wrap bit in one step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/onehot_decoder_fifo.sv
// Buffers binary indices and emits them as registered one-hot vectors.
// Optional range check (drop index >= N_OUT, pulse err_o): ONEHOT_DEC_RANGE_CHK_EN.
module onehot_decoder_fifo
  import onehot_dec_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int IDX_W = idx_width(N_OUT),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  onehot_decoder_fifo_if.slave bus
);
  logic             full, empty;
  logic             push, wr_en, load;
  logic [IDX_W-1:0] head;
  logic [N_OUT-1:0] dec;
  logic [N_OUT-1:0] onehot_q;
  logic             onehot_vld_q;
  logic             err_q;

  // Ready is held low during reset and never looks ahead at a same-cycle pop.
  assign bus.idx_ready_o = rst_ni & ~full;
  assign push            = bus.idx_valid_i & bus.idx_ready_o;
  assign load            = (~onehot_vld_q | bus.onehot_ready_i) & ~empty;

`ifdef ONEHOT_DEC_RANGE_CHK_EN
  logic in_range;
  assign in_range = ({1'b0, bus.idx_i} < (IDX_W+1)'(N_OUT));
  assign wr_en    = push & in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= push & ~in_range;
  end
`else
  assign wr_en = push;
  assign err_q = 1'b0;
`endif

  sync_fifo_ptr #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (wr_en),
    .wr_data (bus.idx_i),
    .rd_en   (load),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (bus.count_o)
  );

  // Per-lane compare; an index past the last lane matches nothing -> all zero.
  for (genvar l = 0; l < N_OUT; l++) begin : g_lane
    assign dec[l] = (head == IDX_W'(l));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      onehot_q     <= '0;
      onehot_vld_q <= 1'b0;
    end else if (~onehot_vld_q | bus.onehot_ready_i) begin
      if (!empty) begin
        onehot_q     <= dec;
        onehot_vld_q <= 1'b1;
      end else begin
        onehot_vld_q <= 1'b0;
      end
    end
  end

  assign bus.onehot_o       = onehot_q;
  assign bus.onehot_valid_o = onehot_vld_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// Self-checking bench for onehot_decoder_fifo: directed table, reset and
// range corner cases, then randomized traffic against a queue-based model.
module tb_onehot_decoder_fifo;
  import onehot_dec_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  onehot_decoder_fifo_if #(.N_OUT(4), .DEPTH(4)) bus ();
  onehot_decoder_fifo_if #(.N_OUT(3), .IDX_W(2), .DEPTH(4)) bus3 ();

  onehot_decoder_fifo #(.N_OUT(4), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));
  onehot_decoder_fifo #(.N_OUT(3), .IDX_W(2), .DEPTH(4)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the buffered indices as a queue plus the presented vector.
  int         q[$];
  bit         m_vld;
  logic [3:0] m_vec;

  task automatic model_reset();
    q.delete();
    m_vld = 1'b0;
    m_vec = 4'b0000;
  endtask

  task automatic model_step(input logic [1:0] idx, input bit v, input bit r);
    bit acc;
    int h;
    acc = v && (q.size() < 4);
    if (!m_vld || r) begin
      if (q.size() > 0) begin
        h     = q.pop_front();
        m_vec = 4'(1 << h);
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
    end
    if (acc) q.push_back(int'(idx));
  endtask

  task automatic check_model();
    chk("rdy", int'(bus.idx_ready_o), int'(q.size() < 4));
    chk("vld", int'(bus.onehot_valid_o), int'(m_vld));
    chk("vec", int'(bus.onehot_o), int'(m_vec));
    chk("cnt", int'(bus.count_o), q.size());
    chk("err", int'(bus.err_o), 0);
  endtask

  task automatic cycle(input logic [1:0] idx, input bit v, input bit r);
    bus.idx_i          = idx;
    bus.idx_valid_i    = v;
    bus.onehot_ready_i = r;
    @(posedge clk_i);
    model_step(idx, v, r);
    @(negedge clk_i);
  endtask

  // Behavioural 4-bit priority encoder (highest set bit wins), -1 if none.
  function automatic int enc4(input logic [3:0] v);
    for (int b = 3; b >= 0; b--) if (v[b]) return b;
    return -1;
  endfunction

  typedef struct {
    logic [1:0] idx;
    bit         v;
    bit         r;
    logic [3:0] vec;
    bit         vld;
    int         cnt;
    bit         rdy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int exp_i;
    int rp;
    // single index 2, then 0..3 back to back, then stall and fill, then full+pop
    tbl[0]  = '{2'd2, 1, 1, 4'b0000, 0, 1, 1};
    tbl[1]  = '{2'd0, 0, 1, 4'b0100, 1, 0, 1};
    tbl[2]  = '{2'd0, 0, 1, 4'b0100, 0, 0, 1};
    tbl[3]  = '{2'd0, 1, 1, 4'b0100, 0, 1, 1};
    tbl[4]  = '{2'd1, 1, 1, 4'b0001, 1, 1, 1};
    tbl[5]  = '{2'd2, 1, 1, 4'b0010, 1, 1, 1};
    tbl[6]  = '{2'd3, 1, 1, 4'b0100, 1, 1, 1};
    tbl[7]  = '{2'd0, 0, 1, 4'b1000, 1, 0, 1};
    tbl[8]  = '{2'd0, 0, 1, 4'b1000, 0, 0, 1};
    tbl[9]  = '{2'd0, 1, 0, 4'b1000, 0, 1, 1};
    tbl[10] = '{2'd1, 1, 0, 4'b0001, 1, 1, 1};
    tbl[11] = '{2'd2, 1, 0, 4'b0001, 1, 2, 1};
    tbl[12] = '{2'd3, 1, 0, 4'b0001, 1, 3, 1};
    tbl[13] = '{2'd0, 1, 0, 4'b0001, 1, 4, 0};
    tbl[14] = '{2'd1, 1, 0, 4'b0001, 1, 4, 0};
    tbl[15] = '{2'd1, 1, 1, 4'b0010, 1, 3, 1};
    tbl[16] = '{2'd1, 1, 1, 4'b0100, 1, 3, 1};

    bus.idx_i = '0;  bus.idx_valid_i = 1'b0;  bus.onehot_ready_i = 1'b1;
    bus3.idx_i = '0; bus3.idx_valid_i = 1'b0; bus3.onehot_ready_i = 1'b1;
    model_reset();

    repeat (2) @(negedge clk_i);
    chk("rst_rdy", int'(bus.idx_ready_o), 0);
    chk("rst_vld", int'(bus.onehot_valid_o), 0);
    chk("rst_vec", int'(bus.onehot_o), 0);
    chk("rst_cnt", int'(bus.count_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    rst_ni = 1'b1;
    #1;
    chk("rel_rdy", int'(bus.idx_ready_o), 1);
    chk("rel_cnt", int'(bus.count_o), 0);
    @(negedge clk_i);

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].idx, tbl[i].v, tbl[i].r);
      chk($sformatf("tbl%0d_vec", i), int'(bus.onehot_o), int'(tbl[i].vec));
      chk($sformatf("tbl%0d_vld", i), int'(bus.onehot_valid_o), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_cnt", i), int'(bus.count_o), tbl[i].cnt);
      chk($sformatf("tbl%0d_rdy", i), int'(bus.idx_ready_o), int'(tbl[i].rdy));
      if (tbl[i].vld) begin
        exp_i = -1;
        for (int b = 0; b < 4; b++) if (tbl[i].vec[b]) exp_i = b;
        chk($sformatf("tbl%0d_enc", i), enc4(bus.onehot_o), exp_i);
      end
    end

    // Mid-stream reset with three entries buffered and a vector held.
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_vld", int'(bus.onehot_valid_o), 0);
    chk("mid_rst_cnt", int'(bus.count_o), 0);
    chk("mid_rst_rdy", int'(bus.idx_ready_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) begin
      cycle(2'd0, 1'b0, 1'b1);
      chk("no_stale", int'(bus.onehot_valid_o), 0);
      check_model();
    end

    // Randomized traffic with alternating downstream back-pressure.
    for (int n = 0; n < 1500; n++) begin
      rp = ((n / 100) % 2 == 0) ? 30 : 90;
      cycle(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < rp));
      check_model();
    end

    // Drain so the shared clock can be stepped for the 3-lane instance.
    repeat (6) cycle(2'd0, 1'b0, 1'b1);

    // Out-of-range index 3 on the 3-lane instance.
    bus3.idx_i = 2'd3; bus3.idx_valid_i = 1'b1; bus3.onehot_ready_i = 1'b1;
    cycle(2'd0, 1'b0, 1'b1);
    bus3.idx_valid_i = 1'b0;
`ifdef ONEHOT_DEC_RANGE_CHK_EN
    chk("oor_err_pulse", int'(bus3.err_o), 1);
    chk("oor_cnt", int'(bus3.count_o), 0);
    chk("oor_vld", int'(bus3.onehot_valid_o), 0);
    cycle(2'd0, 1'b0, 1'b1);
    chk("oor_err_end", int'(bus3.err_o), 0);
    chk("oor_vld2", int'(bus3.onehot_valid_o), 0);
    chk("oor_cnt2", int'(bus3.count_o), 0);
`else
    chk("oor_err", int'(bus3.err_o), 0);
    chk("oor_cnt", int'(bus3.count_o), 1);
    chk("oor_vld", int'(bus3.onehot_valid_o), 0);
    cycle(2'd0, 1'b0, 1'b1);
    chk("oor_vld2", int'(bus3.onehot_valid_o), 1);
    chk("oor_vec2", int'(bus3.onehot_o), 0);
    chk("oor_cnt2", int'(bus3.count_o), 0);
`endif
    cycle(2'd0, 1'b0, 1'b1);
    chk("oor_done_vld", int'(bus3.onehot_valid_o), 0);

    bus3.idx_i = 2'd2; bus3.idx_valid_i = 1'b1;
    cycle(2'd0, 1'b0, 1'b1);
    bus3.idx_valid_i = 1'b0;
    chk("n3_cnt", int'(bus3.count_o), 1);
    cycle(2'd0, 1'b0, 1'b1);
    chk("n3_vld", int'(bus3.onehot_valid_o), 1);
    chk("n3_vec", int'(bus3.onehot_o), 4);
    chk("n3_err", int'(bus3.err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
